// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions used by the MEM/WB writeback path.
//                - load_op_e : load-type encoding carried down the pipeline
//                - STALL_*   : bit indices into the hazard-unit stall vector
//                - is_unaligned_op() : true for the LWL/LWR merge loads
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LB        = 3'd1,
    LBU       = 3'd2,
    LH        = 3'd3,
    LHU       = 3'd4,
    LW        = 3'd5,
    LWL       = 3'd6,
    LWR       = 3'd7
  } load_op_e;

  localparam int STALL_MEM = 0;
  localparam int STALL_WB  = 1;

  function automatic logic is_unaligned_op(input load_op_e op);
    return (op == LWL) || (op == LWR);
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load data aligner. Selects the addressed
//                byte/halfword of a little-endian memory word and sign- or
//                zero-extends it. With MEM_WB_UNALIGNED_EN defined it also
//                builds the LWL/LWR merges with the old rt value; otherwise
//                those codes (and LOAD_NONE) produce zero.
//  Ports       : i_load_op  load type
//                i_off      byte offset (effective address [1:0])
//                i_mem_data raw memory word
//                i_rt       old rt value (merge loads only)
//                o_data     aligned/extended result
//  Macro       : MEM_WB_UNALIGNED_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  load_op_e          i_load_op,
  input  logic [1:0]        i_off,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [DATA_W-1:0] i_rt,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [7:0]  w_b0, w_b1, w_b2, w_b3;

  assign w_b0   = i_mem_data[7:0];
  assign w_b1   = i_mem_data[15:8];
  assign w_b2   = i_mem_data[23:16];
  assign w_b3   = i_mem_data[31:24];
  assign w_byte = i_mem_data[8*i_off +: 8];
  // Halfword alignment is enforced upstream, so only off[1] selects.
  assign w_half = i_off[1] ? i_mem_data[31:16] : i_mem_data[15:0];

`ifndef MEM_WB_UNALIGNED_EN
  logic w_unused_rt;
  assign w_unused_rt = ^i_rt;
`endif

  always_comb begin
    o_data = '0;
    case (i_load_op)
      LB:  o_data = {{24{w_byte[7]}}, w_byte};
      LBU: o_data = {24'h0, w_byte};
      LH:  o_data = {{16{w_half[15]}}, w_half};
      LHU: o_data = {16'h0, w_half};
      LW:  o_data = i_mem_data;
`ifdef MEM_WB_UNALIGNED_EN
      // LWL fills the upper bytes from memory, keeping the low bytes of rt.
      LWL: begin
        case (i_off)
          2'd0:    o_data = {w_b0, i_rt[23:0]};
          2'd1:    o_data = {w_b1, w_b0, i_rt[15:0]};
          2'd2:    o_data = {w_b2, w_b1, w_b0, i_rt[7:0]};
          default: o_data = i_mem_data;
        endcase
      end
      // LWR fills the lower bytes from memory, keeping the high bytes of rt.
      LWR: begin
        case (i_off)
          2'd0:    o_data = i_mem_data;
          2'd1:    o_data = {i_rt[31:24], w_b3, w_b2, w_b1};
          2'd2:    o_data = {i_rt[31:16], w_b3, w_b2};
          default: o_data = {i_rt[31:8], w_b3};
        endcase
      end
`endif
      default: o_data = '0;
    endcase
  end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : MEM/WB pipeline register plus writeback. Latches the retiring
//                instruction, aligns the load data returning from memory in
//                the WB cycle, drives the register-file write port and
//                requests a stall while a load waits for its memory ack.
//  Ports       : clk, rst (async, active-low)
//                stall_i[1:0]   {WB stalled, MEM stalled}
//                flush_i        squash WB entry
//                writeEnable_i, writeAddr_i, writeData_i, loadOp_i, rtData_i
//                               MEM-stage instruction fields
//                memData_i, memAck_i  data-memory return (combinational use)
//                writeEnable_o, writeAddr_o, writeData_o  register-file port
//                stallReq_o     load in WB not yet acknowledged
//  Macro       : MEM_WB_UNALIGNED_EN enables LWL/LWR merge loads
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        stall_i,
  input  logic              flush_i,
  input  logic              writeEnable_i,
  input  logic [ADDR_W-1:0] writeAddr_i,
  input  logic [DATA_W-1:0] writeData_i,
  input  logic [2:0]        loadOp_i,
  input  logic [DATA_W-1:0] rtData_i,
  input  logic [DATA_W-1:0] memData_i,
  input  logic              memAck_i,
  output logic              writeEnable_o,
  output logic [ADDR_W-1:0] writeAddr_o,
  output logic [DATA_W-1:0] writeData_o,
  output logic              stallReq_o
);

  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  load_op_e          r_load_op;
  logic [DATA_W-1:0] w_rt;
  logic [DATA_W-1:0] w_load_data;
  logic              w_op_ok;
  logic              w_is_load;

`ifdef MEM_WB_UNALIGNED_EN
  localparam bit c_unaligned_en = 1'b1;
  logic [DATA_W-1:0] r_rt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rt <= '0;
    end else if (flush_i) begin
      r_rt <= '0;
    end else if (stall_i[STALL_WB]) begin
      r_rt <= r_rt;
    end else if (stall_i[STALL_MEM]) begin
      r_rt <= '0;
    end else begin
      r_rt <= rtData_i;
    end
  end

  assign w_rt = r_rt;
`else
  localparam bit c_unaligned_en = 1'b0;
  logic w_unused_rt;
  assign w_unused_rt = ^rtData_i;
  assign w_rt        = '0;
`endif

  // Update priority: flush, WB hold, MEM bubble, capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_load_op <= LOAD_NONE;
    end else if (flush_i) begin
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_load_op <= LOAD_NONE;
    end else if (stall_i[STALL_WB]) begin
      r_we      <= r_we;
      r_waddr   <= r_waddr;
      r_wdata   <= r_wdata;
      r_load_op <= r_load_op;
    end else if (stall_i[STALL_MEM]) begin
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_load_op <= LOAD_NONE;
    end else begin
      r_we      <= writeEnable_i;
      r_waddr   <= writeAddr_i;
      r_wdata   <= writeData_i;
      r_load_op <= load_op_e'(loadOp_i);
    end
  end

  load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .i_load_op  (r_load_op),
    .i_off      (r_wdata[1:0]),
    .i_mem_data (memData_i),
    .i_rt       (w_rt),
    .o_data     (w_load_data)
  );

  // Merge-load codes are dead when the unaligned feature is compiled out:
  // they neither write nor stall the pipeline.
  assign w_op_ok   = c_unaligned_en || !is_unaligned_op(r_load_op);
  assign w_is_load = (r_load_op != LOAD_NONE);

  assign writeEnable_o = r_we && w_op_ok && (!w_is_load || memAck_i);
  assign stallReq_o    = r_we && w_op_ok && w_is_load && !memAck_i;
  assign writeAddr_o   = r_waddr;
  assign writeData_o   = w_is_load ? w_load_data : r_wdata;

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Directed self-checking bench for mem_wb_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  stall_i;
  logic        flush_i;
  logic        writeEnable_i;
  logic [4:0]  writeAddr_i;
  logic [31:0] writeData_i;
  logic [2:0]  loadOp_i;
  logic [31:0] rtData_i;
  logic [31:0] memData_i;
  logic        memAck_i;
  logic        writeEnable_o;
  logic [4:0]  writeAddr_o;
  logic [31:0] writeData_o;
  logic        stallReq_o;

  int n_pass  = 0;
  int n_total = 0;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .writeEnable_i (writeEnable_i),
    .writeAddr_i   (writeAddr_i),
    .writeData_i   (writeData_i),
    .loadOp_i      (loadOp_i),
    .rtData_i      (rtData_i),
    .memData_i     (memData_i),
    .memAck_i      (memAck_i),
    .writeEnable_o (writeEnable_o),
    .writeAddr_o   (writeAddr_o),
    .writeData_o   (writeData_o),
    .stallReq_o    (stallReq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  task automatic idle_mem;
    writeEnable_i = 1'b0;
    writeAddr_i   = '0;
    writeData_i   = '0;
    loadOp_i      = LOAD_NONE;
    rtData_i      = '0;
  endtask

  // Present an instruction on the MEM inputs for one edge; returns #1 after
  // that edge with the MEM inputs back to a bubble.
  task automatic issue(input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic [2:0] op, input logic [31:0] rt);
    @(negedge clk);
    writeEnable_i = we;
    writeAddr_i   = a;
    writeData_i   = d;
    loadOp_i      = op;
    rtData_i      = rt;
    @(posedge clk);
    #1;
    idle_mem();
  endtask

  task automatic test_reset;
    issue(1'b1, 5'd3, 32'hDEAD_0001, LOAD_NONE, 32'h0);
    #1;
    n_total++;
    if (writeEnable_o !== 1'b1) $display("FAIL reset_pre_we: got %0b expected 1", writeEnable_o);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (writeEnable_o !== 1'b0) $display("FAIL reset_we: got %0b expected 0", writeEnable_o);
    else n_pass++;
    n_total++;
    if (writeAddr_o !== 5'd0) $display("FAIL reset_addr: got %0d expected 0", writeAddr_o);
    else n_pass++;
    n_total++;
    if (writeData_o !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", writeData_o);
    else n_pass++;
    n_total++;
    if (stallReq_o !== 1'b0) $display("FAIL reset_stall: got %0b expected 0", stallReq_o);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_alu;
    issue(1'b1, 5'd5, 32'h1234_5678, LOAD_NONE, 32'h0);
    #1;
    n_total++;
    if (writeEnable_o !== 1'b1) $display("FAIL alu_we: got %0b expected 1", writeEnable_o);
    else n_pass++;
    n_total++;
    if (writeAddr_o !== 5'd5) $display("FAIL alu_addr: got %0d expected 5", writeAddr_o);
    else n_pass++;
    n_total++;
    if (writeData_o !== 32'h1234_5678) $display("FAIL alu_data: got %h expected 12345678", writeData_o);
    else n_pass++;
    n_total++;
    if (stallReq_o !== 1'b0) $display("FAIL alu_stall: got %0b expected 0", stallReq_o);
    else n_pass++;
  endtask

  task automatic test_byte_half;
    logic [2:0]  ops  [5];
    logic [31:0] addr [5];
    logic [31:0] mem  [5];
    logic [31:0] exp  [5];
    ops[0] = LB;  addr[0] = 32'h0000_1002; mem[0] = 32'h0080_FF00; exp[0] = 32'hFFFF_FF80;
    ops[1] = LBU; addr[1] = 32'h0000_1002; mem[1] = 32'h0080_FF00; exp[1] = 32'h0000_0080;
    ops[2] = LHU; addr[2] = 32'h0000_1002; mem[2] = 32'h0080_FF00; exp[2] = 32'h0000_0080;
    ops[3] = LH;  addr[3] = 32'h0000_1000; mem[3] = 32'h1234_8001; exp[3] = 32'hFFFF_8001;
    ops[4] = LW;  addr[4] = 32'h0000_1003; mem[4] = 32'hDEAD_BEEF; exp[4] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 5'd8, addr[i], ops[i], 32'h0);
      memData_i = mem[i];
      memAck_i  = 1'b1;
      #1;
      n_total++;
      if (writeData_o !== exp[i] || writeEnable_o !== 1'b1 || stallReq_o !== 1'b0)
        $display("FAIL load_%0d: got data=%h we=%0b stall=%0b expected data=%h we=1 stall=0",
                 i, writeData_o, writeEnable_o, stallReq_o, exp[i]);
      else n_pass++;
      memAck_i = 1'b0;
    end
  endtask

  task automatic test_ack_wait;
    int writes;
    writes = 0;
    issue(1'b1, 5'd9, 32'h0000_0100, LW, 32'h0);
    stall_i   = 2'b10;
    memData_i = 32'hCAFE_F00D;
    memAck_i  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++;
      if (stallReq_o !== 1'b1 || writeEnable_o !== 1'b0)
        $display("FAIL ackwait_cycle%0d: got stall=%0b we=%0b expected stall=1 we=0",
                 c, stallReq_o, writeEnable_o);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    memAck_i = 1'b1;
    stall_i  = 2'b00;
    #1;
    if (writeEnable_o === 1'b1) writes++;
    n_total++;
    if (writeEnable_o !== 1'b1 || writeData_o !== 32'hCAFE_F00D || writeAddr_o !== 5'd9 || stallReq_o !== 1'b0)
      $display("FAIL ackwait_ack: got we=%0b data=%h addr=%0d stall=%0b expected we=1 data=cafef00d addr=9 stall=0",
               writeEnable_o, writeData_o, writeAddr_o, stallReq_o);
    else n_pass++;
    @(posedge clk);
    #1;
    memAck_i = 1'b0;
    #1;
    if (writeEnable_o === 1'b1) writes++;
    n_total++;
    if (writes != 1) $display("FAIL ackwait_count: got %0d writes expected 1", writes);
    else n_pass++;
  endtask

  task automatic test_bubble;
    @(negedge clk);
    writeEnable_i = 1'b1;
    writeAddr_i   = 5'd12;
    writeData_i   = 32'h0000_00AA;
    loadOp_i      = LOAD_NONE;
    stall_i       = 2'b01;
    @(posedge clk);
    #1;
    idle_mem();
    stall_i = 2'b00;
    #1;
    n_total++;
    if (writeEnable_o !== 1'b0 || writeAddr_o !== 5'd0)
      $display("FAIL bubble: got we=%0b addr=%0d expected we=0 addr=0", writeEnable_o, writeAddr_o);
    else n_pass++;
  endtask

  task automatic test_flush;
    issue(1'b1, 5'd10, 32'h0000_0200, LW, 32'h0);
    stall_i  = 2'b10;
    memAck_i = 1'b0;
    #1;
    n_total++;
    if (stallReq_o !== 1'b1) $display("FAIL flush_pre_stall: got %0b expected 1", stallReq_o);
    else n_pass++;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i   = 1'b0;
    stall_i   = 2'b00;
    memAck_i  = 1'b1;
    memData_i = 32'h5555_AAAA;
    #1;
    n_total++;
    if (writeEnable_o !== 1'b0 || stallReq_o !== 1'b0)
      $display("FAIL flush_cleared: got we=%0b stall=%0b expected we=0 stall=0", writeEnable_o, stallReq_o);
    else n_pass++;
    memAck_i = 1'b0;
  endtask

  task automatic test_flush_ack;
    issue(1'b1, 5'd11, 32'h0000_0300, LW, 32'h0);
    memData_i = 32'h0BAD_F00D;
    memAck_i  = 1'b1;
    flush_i   = 1'b1;
    #1;
    n_total++;
    if (writeEnable_o !== 1'b1 || writeData_o !== 32'h0BAD_F00D)
      $display("FAIL flushack_write: got we=%0b data=%h expected we=1 data=0badf00d", writeEnable_o, writeData_o);
    else n_pass++;
    @(posedge clk);
    #1;
    flush_i  = 1'b0;
    memAck_i = 1'b0;
    #1;
    n_total++;
    if (writeEnable_o !== 1'b0) $display("FAIL flushack_after: got %0b expected 0", writeEnable_o);
    else n_pass++;
  endtask

  task automatic test_we0_and_zero_dest;
    issue(1'b0, 5'd0, 32'h0000_0400, LW, 32'h0);
    memAck_i = 1'b0;
    #1;
    n_total++;
    if (stallReq_o !== 1'b0 || writeEnable_o !== 1'b0)
      $display("FAIL we0_load: got stall=%0b we=%0b expected stall=0 we=0", stallReq_o, writeEnable_o);
    else n_pass++;
    issue(1'b1, 5'd0, 32'h0000_ABCD, LOAD_NONE, 32'h0);
    #1;
    n_total++;
    if (writeEnable_o !== 1'b1 || writeAddr_o !== 5'd0 || writeData_o !== 32'h0000_ABCD)
      $display("FAIL zero_dest: got we=%0b addr=%0d data=%h expected we=1 addr=0 data=0000abcd",
               writeEnable_o, writeAddr_o, writeData_o);
    else n_pass++;
  endtask

  task automatic test_reset_midstall;
    issue(1'b1, 5'd13, 32'h0000_0500, LW, 32'h0);
    stall_i  = 2'b10;
    memAck_i = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    n_total++;
    if (stallReq_o !== 1'b0 || writeEnable_o !== 1'b0)
      $display("FAIL rst_midstall: got stall=%0b we=%0b expected stall=0 we=0", stallReq_o, writeEnable_o);
    else n_pass++;
    memAck_i  = 1'b1;
    memData_i = 32'h7777_7777;
    #1;
    n_total++;
    if (writeEnable_o !== 1'b0) $display("FAIL rst_midstall_ack: got we=%0b expected 0", writeEnable_o);
    else n_pass++;
    memAck_i = 1'b0;
    stall_i  = 2'b00;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unaligned;
`ifdef MEM_WB_UNALIGNED_EN
    issue(1'b1, 5'd14, 32'h0000_0601, LWL, 32'h1122_3344);
    memData_i = 32'hAABB_CCDD;
    memAck_i  = 1'b1;
    #1;
    n_total++;
    if (writeEnable_o !== 1'b1 || writeData_o !== 32'hCCDD_3344)
      $display("FAIL lwl_off1: got we=%0b data=%h expected we=1 data=ccdd3344", writeEnable_o, writeData_o);
    else n_pass++;
    issue(1'b1, 5'd14, 32'h0000_0601, LWR, 32'h1122_3344);
    #1;
    n_total++;
    if (writeEnable_o !== 1'b1 || writeData_o !== 32'h11AA_BBCC)
      $display("FAIL lwr_off1: got we=%0b data=%h expected we=1 data=11aabbcc", writeEnable_o, writeData_o);
    else n_pass++;
    memAck_i = 1'b0;
`else
    issue(1'b1, 5'd14, 32'h0000_0601, LWL, 32'h1122_3344);
    memData_i = 32'hAABB_CCDD;
    memAck_i  = 1'b0;
    #1;
    n_total++;
    if (stallReq_o !== 1'b0 || writeEnable_o !== 1'b0)
      $display("FAIL lwl_disabled_noack: got stall=%0b we=%0b expected stall=0 we=0", stallReq_o, writeEnable_o);
    else n_pass++;
    issue(1'b1, 5'd14, 32'h0000_0601, LWR, 32'h1122_3344);
    memAck_i = 1'b1;
    #1;
    n_total++;
    if (stallReq_o !== 1'b0 || writeEnable_o !== 1'b0)
      $display("FAIL lwr_disabled_ack: got stall=%0b we=%0b expected stall=0 we=0", stallReq_o, writeEnable_o);
    else n_pass++;
    memAck_i = 1'b0;
`endif
  endtask

  initial begin
    rst       = 1'b0;
    stall_i   = 2'b00;
    flush_i   = 1'b0;
    memData_i = '0;
    memAck_i  = 1'b0;
    idle_mem();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    test_reset();
    test_alu();
    test_byte_half();
    test_ack_wait();
    test_bubble();
    test_flush();
    test_flush_ack();
    test_we0_and_zero_dest();
    test_reset_midstall();
    test_unaligned();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mem_wb_stage
`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register and writeback stage between the MEM stage and the register file write port. It latches the retiring instruction's destination, ALU result/effective address and load type. It aligns and sign/zero-extends the data-memory word that returns one cycle later, and drives the register file's write enable, address and data. It also reports a stall request while a load's memory data has not yet been acknowledged.

## Interface
Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (already decided).
- stall_i  in  2  bit0 = MEM stage stalled, bit1 = WB stage stalled (from hazard unit).
- flush_i  in  1  squash the WB register (exception/flush).
- writeEnable_i  in  1  MEM instruction writes a GPR.
- writeAddr_i  in  5  destination GPR.
- writeData_i  in  32  ALU result, or effective address for loads.
- loadOp_i  in  3  load type (package encoding); LOAD_NONE for non-loads.
- rtData_i  in  32  old rt value, used only for unaligned merges.
- memData_i  in  32  raw little-endian word from data memory, valid when memAck_i=1.
- memAck_i  in  1  data memory has returned the word for the load held in WB.
- writeEnable_o  out  1  to register file write enable.
- writeAddr_o  out  5  to register file write address.
- writeData_o  out  32  to register file write data.
- stallReq_o  out  1  WB holds a load whose data is not yet acknowledged.

## Operation
- Stage register fields: we, waddr, wdata, loadOp, rt.
- Update priority at each posedge:
  1. flush_i: bubble (we=0, loadOp=LOAD_NONE, other fields 0).
  2. stall_i[1]: hold all fields.
  3. stall_i[0]=1, stall_i[1]=0: bubble.
  4. Otherwise: capture the *_i inputs.
- Offset: off = wdata[1:0]. Byte k is memData_i[8k+7:8k].
- Output data by loadOp:
  - LOAD_NONE: wdata.
  - LB/LBU: byte[off], sign-extended / zero-extended.
  - LH/LHU: halfword[off[1]], sign-extended / zero-extended; off[0] is ignored (alignment is checked upstream).
  - LW: memData_i; off is ignored.
- Output enable and address:
  - writeAddr_o = waddr.
  - writeEnable_o = we & (loadOp==LOAD_NONE | memAck_i).
- stallReq_o = we & loadOp!=LOAD_NONE & !memAck_i. The hazard unit answers with stall_i[1] and holds the entry until ack arrives, so exactly one write occurs per load.
- Loads with we=0 (e.g. destination $0) never raise stallReq_o.
- A write to $0 is passed through unchanged; the register file discards it.

## Timing
- Reset (rst=0, async): all fields clear immediately. writeEnable_o=0, writeAddr_o=0, writeData_o=0, stallReq_o=0.
- Latency: an instruction presented on the MEM inputs at cycle N reaches the register file write port during cycle N+1. The file commits it at the N+2 edge, and its internal bypass covers same-cycle ID reads.
- memData_i and memAck_i are sampled combinationally during the cycle the load sits in WB. There is no registering on that path.
- Ack arriving in the same cycle as flush_i: the write still happens this cycle; the register clears at the edge.
- Reset mid-stall: the pending load is discarded and no write occurs.

## Configuration
- MEM_WB_UNALIGNED_EN defined: LWL/LWR merge with rt.
  - LWL: off0 {b0,rt[23:0]}; off1 {b1b0,rt[15:0]}; off2 {b2b1b0,rt[7:0]}; off3 full word.
  - LWR: off0 full word; off1 {rt[31:24],b3b2b1}; off2 {rt[31:16],b3b2}; off3 {rt[31:8],b3}.
- Undefined: the rt field is not stored and rtData_i is ignored. LWL/LWR codes force writeEnable_o=0 and stallReq_o=0.

## Structure
- Shared package cpu_pkg holds:
  - Load encodings: LOAD_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, LWL=6, LWR=7.
  - Stall-vector bit indices (STALL_MEM=0, STALL_WB=1).
- One sub-module, load_align, is purely combinational: (loadOp, off, memData, rt) -> data.

## Test plan
- Reset: rst=0 with register loaded -> all outputs 0 immediately, without waiting for a clock edge.
- ALU op: we=1, waddr=5, wdata=0x12345678, LOAD_NONE -> next cycle writeEnable_o=1, writeAddr_o=5, writeData_o=0x12345678, stallReq_o=0.
- Byte/half loads:
  - LB, addr off 2, memData=0x0080FF00 -> 0xFFFFFF80.
  - LBU, same inputs -> 0x00000080.
  - LHU, off 2 -> 0x00000080.
- Ack wait: LW with memAck_i=0 for 3 cycles, stall_i[1]=1 -> stallReq_o=1 and writeEnable_o=0 for 3 cycles. On the ack cycle there is exactly one write of memData_i.
- Bubble and flush: stall_i=2'b01 -> next cycle writeEnable_o=0. flush_i during a stalled load -> entry cleared, no write.
- With MEM_WB_UNALIGNED_EN: LWL off1, mem=0xAABBCCDD, rt=0x11223344 -> 0xCCDD3344. LWR off1 -> 0x11AABBCC.
